// File: rtl/pc_select_if.sv
// rtl/pc_select_if.sv - fetch-side bundle between branch predictor/execute and the next-PC unit
interface pc_select_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic [1:0]       pred_taken;
  logic             btb_hit;
  logic [31:0]      btb_target;
  logic             resolve_valid;
  logic [31:0]      resolve_pc;
  logic             resolve_taken;
  logic [31:0]      resolve_target;
  logic [31:0]      pc;
  logic             fetch_valid;
  logic             flush;
  logic             upd_valid;
  logic             upd_taken;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output stall, pred_taken, btb_hit, btb_target,
    output resolve_valid, resolve_pc, resolve_taken, resolve_target,
    input  pc, fetch_valid, flush, upd_valid, upd_taken, br_count, mp_count
  );

  modport slave (
    input  stall, pred_taken, btb_hit, btb_target,
    input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
    output pc, fetch_valid, flush, upd_valid, upd_taken, br_count, mp_count
  );
endinterface

// File: rtl/pc_select.sv
// rtl/pc_select.sv - next fetch PC selection with in-order prediction queue and mispredict redirect
module pc_select #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4,
  parameter int          CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  pc_select_if.slave  bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);

  logic [31:0]      pc_q;
  logic [PW:0]      count;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             flush_q, upd_valid_q, upd_taken_q;
  logic [CNT_W-1:0] br_q, mp_q;

  logic [31:0] q_pc     [QDEPTH];
  logic        q_taken  [QDEPTH];
  logic [31:0] q_target [QDEPTH];

  logic [31:0] pred_next, correct_pc;
  logic        q_full, fire, push, pop, mispredict, pred_tk;

  always_comb begin
    pred_tk    = bus.btb_hit && bus.pred_taken[1];
    pred_next  = pred_tk ? bus.btb_target : pc_q + 32'd4;
    q_full     = (count == FULL);
    fire       = !q_full && !bus.stall;
    push       = fire && bus.btb_hit;
    pop        = bus.resolve_valid && (count != '0) && (q_pc[rd_ptr] == bus.resolve_pc);
    correct_pc = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 32'd4;
    mispredict = 1'b0;
    if (pop)
      mispredict = (bus.resolve_taken != q_taken[rd_ptr]) ||
                   (bus.resolve_taken && (bus.resolve_target != q_target[rd_ptr]));
    else if (bus.resolve_valid)
      // A taken branch without a queued prediction was fetched fall-through.
      mispredict = bus.resolve_taken;
  end

  // Entry storage needs no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && !mispredict) begin
      q_pc[wr_ptr]     <= pc_q;
      q_taken[wr_ptr]  <= pred_tk;
      q_target[wr_ptr] <= pred_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      flush_q     <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_taken_q <= 1'b0;
      br_q        <= '0;
      mp_q        <= '0;
    end else begin
      flush_q     <= mispredict;
      upd_valid_q <= bus.resolve_valid;
      upd_taken_q <= bus.resolve_valid && bus.resolve_taken;
      if (bus.resolve_valid && (br_q != '1))
        br_q <= br_q + CNT_W'(1);
      if (mispredict && (mp_q != '1))
        mp_q <= mp_q + CNT_W'(1);
      if (mispredict) begin
        pc_q   <= correct_pc;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (fire)
          pc_q <= pred_next;
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)
          count <= count + (PW+1)'(1);
        else if (pop && !push)
          count <= count - (PW+1)'(1);
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = !q_full;
  assign bus.flush       = flush_q;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.br_count    = br_q;
  assign bus.mp_count    = mp_q;
endmodule

// File: tb/tb_pc_select.sv
// tb/tb_pc_select.sv - vector table with expected-output scoreboard for pc_select
module tb_pc_select;
  logic clk = 1'b0;
  logic reset = 1'b1;

  pc_select_if #(.CNT_W(16)) bus ();

  pc_select #(.RESET_PC(32'h0), .QDEPTH(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [1:0]  pt;
    logic        h;
    logic [31:0] t;
    logic        rv;
    logic [31:0] rp;
    logic        rt;
    logic [31:0] rtg;
    logic [31:0] epc;
    logic        efv, efl, euv, eut;
    logic [15:0] ebr, emp;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic s, input logic [1:0] pt, input logic h, input logic [31:0] t,
                              input logic rv, input logic [31:0] rp, input logic rt, input logic [31:0] rtg,
                              input logic [31:0] epc, input logic efv, input logic efl, input logic euv,
                              input logic eut, input logic [15:0] ebr, input logic [15:0] emp);
    vec_t v;
    v.s = s; v.pt = pt; v.h = h; v.t = t; v.rv = rv; v.rp = rp; v.rt = rt; v.rtg = rtg;
    v.epc = epc; v.efv = efv; v.efl = efl; v.euv = euv; v.eut = eut; v.ebr = ebr; v.emp = emp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.stall = v.s; bus.pred_taken = v.pt; bus.btb_hit = v.h; bus.btb_target = v.t;
    bus.resolve_valid = v.rv; bus.resolve_pc = v.rp; bus.resolve_taken = v.rt; bus.resolve_target = v.rtg;
  endtask

  task automatic compare(input string name);
    vec_t e;
    e = exp_q.pop_front();
    n_vec++;
    if (bus.pc !== e.epc || bus.fetch_valid !== e.efv || bus.flush !== e.efl ||
        bus.upd_valid !== e.euv || bus.upd_taken !== e.eut ||
        bus.br_count !== e.ebr || bus.mp_count !== e.emp) begin
      n_err++;
      $display("FAIL %s: got pc=%h fv=%b flush=%b uv=%b ut=%b br=%h mp=%h, want pc=%h fv=%b flush=%b uv=%b ut=%b br=%h mp=%h",
               name, bus.pc, bus.fetch_valid, bus.flush, bus.upd_valid, bus.upd_taken, bus.br_count, bus.mp_count,
               e.epc, e.efv, e.efl, e.euv, e.eut, e.ebr, e.emp);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  task automatic check_now(input logic [31:0] epc, input logic efv, input logic efl, input logic euv,
                           input logic eut, input logic [15:0] ebr, input logic [15:0] emp, input string name);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, epc, efv, efl, euv, eut, ebr, emp));
    compare(name);
  endtask

  initial begin
    // sequence through redirects, queue fill/drain and PC wrap
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,                32'h4,   1,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,                32'h8,   1,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,                32'hC,   1,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,                32'h10,  1,0,0,0, 0,0));
    tbl.push_back(mk(0,3,1,32'h80,     0,0,0,0,                32'h80,  1,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,          1,32'h10,1,32'h80,      32'h84,  1,0,1,1, 1,0));
    tbl.push_back(mk(0,3,1,32'h10,     0,0,0,0,                32'h10,  1,0,0,0, 1,0));
    tbl.push_back(mk(1,0,0,0,          1,32'h84,0,0,           32'h88,  1,1,1,0, 2,1));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,                32'h8C,  1,0,0,0, 2,1));
    tbl.push_back(mk(0,3,1,32'h300,    1,32'h20,1,32'h200,     32'h200, 1,1,1,1, 3,2));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,                32'h204, 1,0,0,0, 3,2));
    tbl.push_back(mk(0,1,1,32'h999,    0,0,0,0,                32'h208, 1,0,0,0, 3,2));
    tbl.push_back(mk(0,1,1,32'h999,    0,0,0,0,                32'h20C, 1,0,0,0, 3,2));
    tbl.push_back(mk(0,1,1,32'h999,    0,0,0,0,                32'h210, 1,0,0,0, 3,2));
    tbl.push_back(mk(0,1,1,32'h999,    0,0,0,0,                32'h214, 0,0,0,0, 3,2));
    tbl.push_back(mk(0,1,1,32'h999,    0,0,0,0,                32'h214, 0,0,0,0, 3,2));
    tbl.push_back(mk(0,1,1,32'h999,    1,32'h204,0,0,          32'h214, 1,0,1,0, 4,2));
    tbl.push_back(mk(1,1,1,32'h999,    0,0,0,0,                32'h214, 1,0,0,0, 4,2));
    tbl.push_back(mk(0,1,1,32'h999,    1,32'h208,0,0,          32'h218, 1,0,1,0, 5,2));
    tbl.push_back(mk(0,0,0,0,          1,32'h20C,1,32'h500,    32'h500, 1,1,1,1, 6,3));
    tbl.push_back(mk(0,2,1,32'h600,    0,0,0,0,                32'h600, 1,0,0,0, 6,3));
    tbl.push_back(mk(0,0,0,0,          1,32'h500,1,32'h604,    32'h604, 1,1,1,1, 7,4));
    tbl.push_back(mk(0,0,0,0,          1,32'h700,0,0,          32'h608, 1,0,1,0, 8,4));
    tbl.push_back(mk(0,0,0,0,          1,32'h0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 1,1,1,1, 9,5));
    tbl.push_back(mk(0,0,0,0,          0,0,0,0,                32'h0,   1,0,0,0, 9,5));
    tbl.push_back(mk(0,0,0,0,          1,32'h1000,1,32'h30,    32'h30,  1,1,1,1, 10,6));
    tbl.push_back(mk(0,1,1,32'h999,    0,0,0,0,                32'h34,  1,0,0,0, 10,6));
    tbl.push_back(mk(0,1,1,32'h999,    0,0,0,0,                32'h38,  1,0,0,0, 10,6));
    tbl.push_back(mk(0,1,1,32'h999,    0,0,0,0,                32'h3C,  1,0,0,0, 10,6));
    tbl.push_back(mk(0,1,1,32'h999,    0,0,0,0,                32'h40,  0,0,0,0, 10,6));
    tbl.push_back(mk(0,1,1,32'h999,    0,0,0,0,                32'h40,  0,0,0,0, 10,6));

    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    check_now(32'h0, 1, 0, 0, 0, 0, 0, "in_reset");
    reset = 1'b0;
    check_now(32'h0, 1, 0, 0, 0, 0, 0, "reset_state");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // async reset mid-cycle with a full queue and pc=0x40
    #2;
    reset = 1'b1;
    #1;
    check_now(32'h0, 1, 0, 0, 0, 0, 0, "async_reset");
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_now(32'h0, 1, 0, 0, 0, 0, 0, "post_reset_pc0");
    step(mk(0,0,0,0, 0,0,0,0, 32'h4, 1,0,0,0, 0,0), "post_reset_pc4");
    step(mk(0,0,0,0, 0,0,0,0, 32'h8, 1,0,0,0, 0,0), "post_reset_pc8");
    step(mk(0,0,0,0, 0,0,0,0, 32'hC, 1,0,0,0, 0,0), "post_reset_pcC");

    // branch counter saturation
    drive(mk(0,0,0,0, 1,32'hFFFF_0000,0,0, 0,0,0,0,0,0,0));
    repeat (65536) @(posedge clk);
    #1;
    check_now(32'h4_000C, 1, 0, 1, 0, 16'hFFFF, 16'h0, "br_sat_reach");
    step(mk(0,0,0,0, 1,32'hFFFF_0000,0,0, 32'h4_0010, 1,0,1,0, 16'hFFFF,16'h0), "br_sat_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pc_select.md
# pc_select

Fetch-stage next-PC unit sitting directly downstream of the branch predictor. Each cycle it combines the predictor's 2-bit counter and the BTB hit/target into the next fetch PC. It records every predicted-taken candidate in an in-order prediction queue and checks the queue against branch resolutions from execute. On a mispredict it redirects fetch, flushes younger work, and returns the actual outcome to the predictor as its `branch` training input.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `QDEPTH`, 4, prediction queue entries (power of 2, ≥2)
- `CNT_W`, 16, width of performance counters

- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state immediately
- `stall` in 1: downstream cannot accept a fetch this cycle
- `pred_taken` in 2: predictor counter for current `pc`; bit[1]=1 means predict taken
- `btb_hit` in 1: BTB holds an entry for current `pc`
- `btb_target` in 32: BTB target for current `pc`
- `resolve_valid` in 1: execute resolved one branch this cycle
- `resolve_pc` in 32: PC of the resolved branch
- `resolve_taken` in 1: actual direction
- `resolve_target` in 32: actual taken target
- `pc` out 32: current fetch PC (registered)
- `fetch_valid` out 1: `pc` is a valid fetch this cycle
- `flush` out 1: kill all in-flight instructions younger than the resolved branch (registered, 1-cycle pulse)
- `upd_valid` out 1: predictor training strobe (registered)
- `upd_taken` out 1: actual direction for training (the predictor's `branch` input)
- `br_count` out CNT_W: resolved branches, saturating
- `mp_count` out CNT_W: mispredicts, saturating

## Operation
- Predicted next: `btb_hit && pred_taken[1]` ? `btb_target` : `pc + 4`. Addition is 32-bit modulo; wrap from 32'hFFFF_FFFC to 0 is legal.
- `fetch_valid = !q_full` (registered occupancy). Fetch fires when `fetch_valid && !stall`; `pc` then loads predicted next. Otherwise `pc` holds.
- Push: when fetch fires and `btb_hit` is set, enqueue {pc, pred_taken[1], predicted target}.
- Resolve, when `resolve_valid`:
  - Head valid and head.pc == `resolve_pc`: pop the head. Mispredict = (`resolve_taken` != head.taken) OR (`resolve_taken` AND `resolve_target` != head.target).
  - Otherwise (no BTB entry was used): no pop. Mispredict = `resolve_taken`.
  - Correct PC = `resolve_taken` ? `resolve_target` : `resolve_pc + 4`.
- On mispredict: next cycle `pc` = correct PC regardless of `stall` or `q_full`; `flush`=1; queue emptied. The same-cycle push and pop are discarded.
- Simultaneous push and pop with no mispredict: occupancy unchanged, both applied.
- `resolve_valid` with an empty queue is legal and takes the no-match path.
- Every resolve: `upd_valid`=1 and `upd_taken`=`resolve_taken` in the next cycle. `br_count`+1. `mp_count`+1 on mispredict. Both saturate at all-ones.

## Timing
- Reset values: `pc`=RESET_PC, `fetch_valid`=1, `flush`=0, `upd_valid`=0, `upd_taken`=0, counters 0, queue empty.
- Reset asserted mid-operation clears the queue and counters asynchronously; the first fetch after deassertion is RESET_PC.
- Redirect latency is 1 cycle: resolve in cycle N gives the corrected `pc` and `flush` in N+1, with `fetch_valid`=1 in N+1.
- Training latency is 1 cycle: `upd_*` valid in N+1 for a resolve in N.
- Queue full: `fetch_valid`=0 in the cycle after occupancy reaches QDEPTH, and `pc` holds. A pop in the current cycle restores `fetch_valid` in the next.
- `stall` freezes `pc` and blocks the push; it does not block resolve or redirect.

## Test plan
- Reset with `pc` at 0x40 → `pc`=0x0 immediately; after release and 3 unstalled cycles with `btb_hit`=0 → `pc`=0x0, 0x4, 0x8, 0xC.
- At `pc`=0x10, `btb_hit`=1, `btb_target`=0x80, `pred_taken`=2'b11 → next `pc`=0x80, queue occupancy 1. Then resolve {0x10, taken, 0x80} → no flush, `upd_taken`=1, `br_count`=1, `mp_count`=0.
- Same push, then resolve {0x10, not taken} → next cycle `pc`=0x14, `flush`=1, queue empty, `mp_count`=1.
- Resolve {0x20, taken, 0x200} with no matching head → `pc`=0x200 and `flush`=1 next cycle. A push issued in the same cycle is discarded.
- Four BTB-hit fetches with no resolve → `fetch_valid`=0 and `pc` frozen. Resolve the head correctly → `fetch_valid`=1 the next cycle.
- Force `br_count` to all-ones by 65 536 resolves, then one more → `br_count` stays 16'hFFFF.
